ram_arbiter: RTL and testbench

- Front-end controller for the 256x8 two-read/one-write RAM.
- Port 1 (read-only) is dedicated to instruction fetch. Port 2 (read or write) is shared between the load/store unit (LSU) and the debug/loader interface.
- Arbitrates port 2 per cycle, drives all RAM control and address lines, and returns tagged read data with a registered valid.
- Sits between the core's fetch/LSU, the debug loader, and the RAM instance.

---
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for the RAM arbiter: fetch, LSU and debug channels.
// Requesters drive the master modport; the arbiter takes the slave modport.
interface ram_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;

   logic              lsu_req;
   logic              lsu_we;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic              lsu_gnt;
   logic              lsu_rvalid;
   logic [DATA_W-1:0] lsu_rdata;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_lock;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;

   modport master (
      output fetch_req, fetch_addr,
      input  fetch_rvalid, fetch_rdata,
      output lsu_req, lsu_we, lsu_addr, lsu_wdata,
      input  lsu_gnt, lsu_rvalid, lsu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
      input  dbg_gnt, dbg_rvalid, dbg_rdata
   );

   modport slave (
      input  fetch_req, fetch_addr,
      output fetch_rvalid, fetch_rdata,
      input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
      output lsu_gnt, lsu_rvalid, lsu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
      output dbg_gnt, dbg_rvalid, dbg_rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Port-2 arbiter for the 2R/1W RAM; same-cycle grant, read data valid 1 cycle after accept.
// Losers see gnt=0 and must hold req/inputs; fetch on port 1 is never stalled.
module ram_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   ram_arbiter_if.slave      bus,
   output logic [ADDR_W-1:0] ram_addr_port_1,
   output logic [ADDR_W-1:0] ram_addr_port_2,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_write_en,
   output logic              ram_out_en,
   input  logic [DATA_W-1:0] ram_data_out_port_1,
   input  logic [DATA_W-1:0] ram_data_out_port_2
);
   typedef enum logic {LAST_LSU, LAST_DBG} last_t;

   last_t last_grant;
   logic  lsu_win;
   logic  dbg_win;
   logic  fetch_rvalid_q;
   logic  lsu_rvalid_q;
   logic  dbg_rvalid_q;

   always_comb begin
      lsu_win = 1'b0;
      dbg_win = 1'b0;
      if (!rst) begin
         if (bus.dbg_lock) begin
            dbg_win = bus.dbg_req;
         end else if (bus.lsu_req && !bus.dbg_req) begin
            lsu_win = 1'b1;
         end else if (bus.dbg_req && !bus.lsu_req) begin
            dbg_win = 1'b1;
         end else if (bus.lsu_req && bus.dbg_req) begin
            if (ARB_MODE == 1 || last_grant == LAST_DBG) begin
               lsu_win = 1'b1;
            end else begin
               dbg_win = 1'b1;
            end
         end
      end
   end

   // Port-2 lines idle at zero when nobody owns the port.
   always_comb begin
      ram_addr_port_2 = '0;
      ram_data_in     = '0;
      ram_write_en    = 1'b0;
      ram_out_en      = 1'b0;
      if (lsu_win) begin
         ram_addr_port_2 = bus.lsu_addr;
         ram_write_en    = bus.lsu_we;
         ram_out_en      = !bus.lsu_we;
         if (bus.lsu_we) ram_data_in = bus.lsu_wdata;
      end else if (dbg_win) begin
         ram_addr_port_2 = bus.dbg_addr;
         ram_write_en    = bus.dbg_we;
         ram_out_en      = !bus.dbg_we;
         if (bus.dbg_we) ram_data_in = bus.dbg_wdata;
      end
   end

   // The per-requester rvalid flops double as the port-2 owner tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant     <= LAST_DBG;
         fetch_rvalid_q <= 1'b0;
         lsu_rvalid_q   <= 1'b0;
         dbg_rvalid_q   <= 1'b0;
      end else begin
         fetch_rvalid_q <= bus.fetch_req;
         lsu_rvalid_q   <= lsu_win && !bus.lsu_we;
         dbg_rvalid_q   <= dbg_win && !bus.dbg_we;
         if (lsu_win) begin
            last_grant <= LAST_LSU;
         end else if (dbg_win) begin
            last_grant <= LAST_DBG;
         end
      end
   end

   assign ram_addr_port_1  = bus.fetch_addr;
   assign bus.lsu_gnt      = lsu_win;
   assign bus.dbg_gnt      = dbg_win;
   assign bus.fetch_rvalid = fetch_rvalid_q;
   assign bus.lsu_rvalid   = lsu_rvalid_q;
   assign bus.dbg_rvalid   = dbg_rvalid_q;

   // Masking hides the RAM's floating port-2 output when no read is pending.
   assign bus.fetch_rdata = fetch_rvalid_q ? ram_data_out_port_1 : '0;
   assign bus.lsu_rdata   = lsu_rvalid_q   ? ram_data_out_port_2 : '0;
   assign bus.dbg_rdata   = dbg_rvalid_q   ? ram_data_out_port_2 : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin instance driven from a vector table with a response
// scoreboard, plus a fixed-priority instance exercised by a hand-written contention sequence.
module tb_ram_arbiter;
   logic clk;
   logic rst0, rst1;
   logic mem_init;

   ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
   ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();

   logic [7:0] a1_0, a2_0, din0, d1_0, d2_0;
   logic       we0, oe0;
   logic [7:0] a1_1, a2_1, din1, d1_1, d2_1;
   logic       we1, oe1;
   logic [7:0] mem0 [256];
   logic [7:0] mem1 [256];
   logic [7:0] shadow [256];

   ram_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(0)) u0 (
      .clk(clk), .rst(rst0), .bus(b0),
      .ram_addr_port_1(a1_0), .ram_addr_port_2(a2_0), .ram_data_in(din0),
      .ram_write_en(we0), .ram_out_en(oe0),
      .ram_data_out_port_1(d1_0), .ram_data_out_port_2(d2_0)
   );

   ram_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(1)) u1 (
      .clk(clk), .rst(rst1), .bus(b1),
      .ram_addr_port_1(a1_1), .ram_addr_port_2(a2_1), .ram_data_in(din1),
      .ram_write_en(we1), .ram_out_en(oe1),
      .ram_data_out_port_1(d1_1), .ram_data_out_port_2(d2_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous read-before-write RAMs; 0xEE stands in for the floating port-2 bus.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) begin
            mem0[i] <= 8'(i);
            mem1[i] <= 8'(i);
         end
      end else begin
         d1_0 <= mem0[a1_0];
         d2_0 <= oe0 ? mem0[a2_0] : 8'hEE;
         if (we0) mem0[a2_0] <= din0;
         d1_1 <= mem1[a1_1];
         d2_1 <= oe1 ? mem1[a2_1] : 8'hEE;
         if (we1) mem1[a2_1] <= din1;
      end
   end

   typedef struct {
      logic rst;
      logic lr, lw; logic [7:0] la, ld;
      logic dr, dw; logic [7:0] da, dd;
      logic lock;
      logic fr; logic [7:0] fa;
      logic elg, edg;
   } vec_t;

   typedef struct {
      logic frv; logic [7:0] fd;
      logic lrv; logic [7:0] ld;
      logic drv; logic [7:0] dd;
   } rsp_t;

   vec_t tbl[$];
   rsp_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic rst, input logic lr, input logic lw,
                               input logic [7:0] la, input logic [7:0] ld,
                               input logic dr, input logic dw,
                               input logic [7:0] da, input logic [7:0] dd,
                               input logic lock, input logic fr, input logic [7:0] fa,
                               input logic elg, input logic edg);
      vec_t v;
      v.rst = rst; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
      v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.lock = lock;
      v.fr = fr; v.fa = fa; v.elg = elg; v.edg = edg;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      vec_t v;
      rsp_t r, e;
      logic       ewe, eoe;
      logic [7:0] ea2, edin;

      mem_init = 1'b1;
      rst0 = 1'b1; rst1 = 1'b1;
      b0.fetch_req = 0; b0.fetch_addr = 0; b0.lsu_req = 0; b0.lsu_we = 0; b0.lsu_addr = 0;
      b0.lsu_wdata = 0; b0.dbg_req = 0; b0.dbg_we = 0; b0.dbg_addr = 0; b0.dbg_wdata = 0;
      b0.dbg_lock = 0;
      b1.fetch_req = 0; b1.fetch_addr = 0; b1.lsu_req = 0; b1.lsu_we = 0; b1.lsu_addr = 0;
      b1.lsu_wdata = 0; b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_addr = 0; b1.dbg_wdata = 0;
      b1.dbg_lock = 0;
      for (int i = 0; i < 256; i++) shadow[i] = 8'(i);

      //                rst lr lw la     ld     dr dw da     dd     lk fr fa     lg dg
      tbl.push_back(mk(1, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h03, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 8'h08, 1, 0));
      tbl.push_back(mk(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h10, 0, 0));
      tbl.push_back(mk(0, 1, 1, 8'h20, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1, 8'h20, 0, 1));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h20, 0, 0));
      tbl.push_back(mk(0, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00, 1, 0, 8'h00, 0, 1));
      tbl.push_back(mk(0, 1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 1, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(1, 1, 0, 8'h41, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 1, 0, 8'h06, 8'h00, 1, 0, 8'h07, 8'h00, 0, 0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0));

      @(posedge clk);
      #1 mem_init = 1'b0;
      @(negedge clk);

      foreach (tbl[k]) begin
         v = tbl[k];
         rst0 = v.rst;
         b0.lsu_req = v.lr; b0.lsu_we = v.lw; b0.lsu_addr = v.la; b0.lsu_wdata = v.ld;
         b0.dbg_req = v.dr; b0.dbg_we = v.dw; b0.dbg_addr = v.da; b0.dbg_wdata = v.dd;
         b0.dbg_lock = v.lock; b0.fetch_req = v.fr; b0.fetch_addr = v.fa;
         #1;
         ewe  = (v.elg && v.lw) || (v.edg && v.dw);
         eoe  = (v.elg && !v.lw) || (v.edg && !v.dw);
         ea2  = v.elg ? v.la : (v.edg ? v.da : 8'h00);
         edin = (v.elg && v.lw) ? v.ld : ((v.edg && v.dw) ? v.dd : 8'h00);
         chk($sformatf("v%0d lsu_gnt", k), 32'(b0.lsu_gnt), 32'(v.elg));
         chk($sformatf("v%0d dbg_gnt", k), 32'(b0.dbg_gnt), 32'(v.edg));
         chk($sformatf("v%0d write_en", k), 32'(we0), 32'(ewe));
         chk($sformatf("v%0d out_en", k), 32'(oe0), 32'(eoe));
         chk($sformatf("v%0d addr_port_2", k), 32'(a2_0), 32'(ea2));
         chk($sformatf("v%0d data_in", k), 32'(din0), 32'(edin));
         chk($sformatf("v%0d addr_port_1", k), 32'(a1_0), 32'(v.fa));
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("v%0d fetch_rvalid", k), 32'(b0.fetch_rvalid), 32'(e.frv));
            chk($sformatf("v%0d fetch_rdata", k), 32'(b0.fetch_rdata), 32'(e.fd));
            chk($sformatf("v%0d lsu_rvalid", k), 32'(b0.lsu_rvalid), 32'(e.lrv));
            chk($sformatf("v%0d lsu_rdata", k), 32'(b0.lsu_rdata), 32'(e.ld));
            chk($sformatf("v%0d dbg_rvalid", k), 32'(b0.dbg_rvalid), 32'(e.drv));
            chk($sformatf("v%0d dbg_rdata", k), 32'(b0.dbg_rdata), 32'(e.dd));
         end
         r.frv = 1'b0; r.fd = 8'h00; r.lrv = 1'b0; r.ld = 8'h00; r.drv = 1'b0; r.dd = 8'h00;
         if (!v.rst) begin
            r.frv = v.fr;
            r.fd  = v.fr ? shadow[v.fa] : 8'h00;
            r.lrv = v.elg && !v.lw;
            r.ld  = r.lrv ? shadow[v.la] : 8'h00;
            r.drv = v.edg && !v.dw;
            r.dd  = r.drv ? shadow[v.da] : 8'h00;
            if (v.elg && v.lw) shadow[v.la] = v.ld;
            if (v.edg && v.dw) shadow[v.da] = v.dd;
         end
         sbq.push_back(r);
         @(negedge clk);
      end

      // Fixed-priority instance: LSU holds port 2 under contention, dbg waits.
      rst1 = 1'b0;
      b1.lsu_req = 1; b1.lsu_we = 0; b1.lsu_addr = 8'h0A;
      b1.dbg_req = 1; b1.dbg_we = 0; b1.dbg_addr = 8'h0B;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("p%0d lsu_gnt", c), 32'(b1.lsu_gnt), 32'd1);
         chk($sformatf("p%0d dbg_gnt", c), 32'(b1.dbg_gnt), 32'd0);
         if (c > 0) begin
            chk($sformatf("p%0d lsu_rvalid", c), 32'(b1.lsu_rvalid), 32'd1);
            chk($sformatf("p%0d lsu_rdata", c), 32'(b1.lsu_rdata), 32'h0A);
            chk($sformatf("p%0d dbg_rvalid", c), 32'(b1.dbg_rvalid), 32'd0);
         end
         @(negedge clk);
      end
      b1.lsu_req = 0;
      #1;
      chk("p3 dbg_gnt", 32'(b1.dbg_gnt), 32'd1);
      chk("p3 lsu_gnt", 32'(b1.lsu_gnt), 32'd0);
      chk("p3 lsu_rvalid", 32'(b1.lsu_rvalid), 32'd1);
      @(negedge clk);
      b1.dbg_req = 0;
      #1;
      chk("p4 dbg_rvalid", 32'(b1.dbg_rvalid), 32'd1);
      chk("p4 dbg_rdata", 32'(b1.dbg_rdata), 32'h0B);
      chk("p4 lsu_rvalid", 32'(b1.lsu_rvalid), 32'd0);
      chk("p4 lsu_rdata", 32'(b1.lsu_rdata), 32'h00);
      @(negedge clk);
      #1;
      chk("p5 dbg_rvalid", 32'(b1.dbg_rvalid), 32'd0);
      chk("p5 dbg_rdata masked", 32'(b1.dbg_rdata), 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
